// File: rtl/data_mem_responder_pkg.sv
// pkg_mem_map: shared memory-map definitions for data_mem_responder.
//   - MMIO register offsets inside the 64-byte window
//   - region-select enum produced by the address decoder
//   - mtimecmp reset value
//   - byte-lane merge helper used by every byte-enabled register
package pkg_mem_map;

   localparam logic [5:0] MMIO_MTIME_LO    = 6'h00;
   localparam logic [5:0] MMIO_MTIME_HI    = 6'h04;
   localparam logic [5:0] MMIO_MTIMECMP_LO = 6'h08;
   localparam logic [5:0] MMIO_MTIMECMP_HI = 6'h0C;
   localparam logic [5:0] MMIO_TOHOST      = 6'h10;
   localparam logic [5:0] MMIO_CONSOLE     = 6'h14;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_MMIO,
      REGION_NONE
   } region_e;

   localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   // Lane i of the result comes from new_w when be[i] is set, else from old_w.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/data_mem_responder_mmio_timer.sv
// mmio_timer: machine timer block of the MMIO window.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   offset_i           word-aligned MMIO offset of the current access
//   we_i               byte strobes, already qualified by an MMIO hit
//   wdata_i            lane-aligned store data
//   mtime_o            current mtime register
//   mtimecmp_o         current mtimecmp register
//   timer_irq_o        registered (mtime >= mtimecmp)
module mmio_timer
   import pkg_mem_map::*;
#(
   parameter int TICK_DIV = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [5:0]  offset_i,
   input  logic [3:0]  we_i,
   input  logic [31:0] wdata_i,
   output logic [63:0] mtime_o,
   output logic [63:0] mtimecmp_o,
   output logic        timer_irq_o
);

   logic [31:0] presc_q, presc_d;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] cmp_q, cmp_d;
   logic        irq_q;
   logic        tick;
   logic        mtime_wr;

   always_comb begin
      tick     = (presc_q == 32'(TICK_DIV - 1));
      presc_d  = tick ? 32'd0 : presc_q + 32'd1;
      mtime_d  = mtime_q;
      cmp_d    = cmp_q;
      mtime_wr = (|we_i) && ((offset_i == MMIO_MTIME_LO) || (offset_i == MMIO_MTIME_HI));

      if (|we_i) begin
         case (offset_i)
            MMIO_MTIME_LO:    mtime_d[31:0]  = merge_lanes(mtime_q[31:0],  wdata_i, we_i);
            MMIO_MTIME_HI:    mtime_d[63:32] = merge_lanes(mtime_q[63:32], wdata_i, we_i);
            MMIO_MTIMECMP_LO: cmp_d[31:0]    = merge_lanes(cmp_q[31:0],    wdata_i, we_i);
            MMIO_MTIMECMP_HI: cmp_d[63:32]   = merge_lanes(cmp_q[63:32],   wdata_i, we_i);
            default: ;
         endcase
      end

      // A software write to either half wins over the tick; the whole
      // 64-bit counter skips that increment while the prescaler keeps going.
      if (!mtime_wr && tick) mtime_d = mtime_q + 64'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_q <= '0;
         mtime_q <= '0;
         cmp_q   <= MTIMECMP_RESET;
         irq_q   <= 1'b0;
      end else begin
         presc_q <= presc_d;
         mtime_q <= mtime_d;
         cmp_q   <= cmp_d;
         irq_q   <= (mtime_q >= cmp_q);
      end
   end

   assign mtime_o     = mtime_q;
   assign mtimecmp_o  = cmp_q;
   assign timer_irq_o = irq_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: target side of the core's unified memory bus.
// Byte-enabled word RAM plus a 64-byte MMIO window (timer, tohost, console).
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   memory__address            byte address from the core
//   memory__write_data         lane-aligned store data
//   memory__write_enable       per-lane write strobes, 0 = read/idle
//   memory__read_data          combinational read word
//   timer_irq                  machine timer interrupt (level)
//   halt                       sticky, set by a nonzero tohost write
//   console_valid/console_data one-cycle strobe with the console byte
//   bus_error                  sticky, access outside RAM and MMIO
module data_mem_responder
   import pkg_mem_map::*;
#(
   parameter int          MEM_WORDS = 4096,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
   parameter int          TICK_DIV  = 1,
   parameter string       INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] memory__address,
   input  logic [31:0] memory__write_data,
   input  logic [3:0]  memory__write_enable,
   output logic [31:0] memory__read_data,
   output logic        timer_irq,
   output logic        halt,
   output logic        console_valid,
   output logic [7:0]  console_data,
   output logic        bus_error
);

   localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;

   logic [31:0]      mem_q [MEM_WORDS];
   region_e          region;
   logic [5:0]       offset;
   logic [IDX_W-1:0] word_idx;
   logic [3:0]       mmio_we;
   logic [63:0]      mtime, mtimecmp;
   logic [31:0]      tohost_q, tohost_d;
   logic             halt_q, halt_d;
   logic             cvalid_q, cvalid_d;
   logic [7:0]       cdata_q, cdata_d;
   logic             berr_q, berr_d;
   logic             unused_addr_bits;

   assign offset           = {memory__address[5:2], 2'b00};
   assign word_idx         = memory__address[IDX_W+1:2];
   assign unused_addr_bits = ^memory__address[1:0];

   always_comb begin
      if ({1'b0, memory__address} < RAM_BYTES)
         region = REGION_RAM;
      else if (memory__address[31:6] == MMIO_BASE[31:6])
         region = REGION_MMIO;
      else
         region = REGION_NONE;
   end

   assign mmio_we = (region == REGION_MMIO) ? memory__write_enable : 4'b0000;

   mmio_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_timer (
      .clk_i       (clk),
      .rst_ni      (reset),
      .offset_i    (offset),
      .we_i        (mmio_we),
      .wdata_i     (memory__write_data),
      .mtime_o     (mtime),
      .mtimecmp_o  (mtimecmp),
      .timer_irq_o (timer_irq)
   );

   // Combinational read: the core latches this on the following edge.
   always_comb begin
      memory__read_data = '0;
      case (region)
         REGION_RAM: memory__read_data = mem_q[word_idx];
         REGION_MMIO: begin
            case (offset)
               MMIO_MTIME_LO:    memory__read_data = mtime[31:0];
               MMIO_MTIME_HI:    memory__read_data = mtime[63:32];
               MMIO_MTIMECMP_LO: memory__read_data = mtimecmp[31:0];
               MMIO_MTIMECMP_HI: memory__read_data = mtimecmp[63:32];
               MMIO_TOHOST:      memory__read_data = tohost_q;
               default:          memory__read_data = '0;
            endcase
         end
         default: memory__read_data = '0;
      endcase
   end

   // RAM has no reset so its contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (region == REGION_RAM) begin
         for (int i = 0; i < 4; i++) begin
            if (memory__write_enable[i])
               mem_q[word_idx][8*i +: 8] <= memory__write_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      tohost_d = tohost_q;
      halt_d   = halt_q;
      cvalid_d = 1'b0;
      cdata_d  = cdata_q;
      berr_d   = berr_q;

      if (|mmio_we) begin
         if (offset == MMIO_TOHOST) begin
            tohost_d = merge_lanes(tohost_q, memory__write_data, mmio_we);
            if (tohost_d != '0) halt_d = 1'b1;
         end
         if ((offset == MMIO_CONSOLE) && mmio_we[0]) begin
            cvalid_d = 1'b1;
            cdata_d  = memory__write_data[7:0];
         end
      end

      // Address 0 with no strobes is the bus idle pattern, never an error.
      if ((region == REGION_NONE) &&
          ((memory__write_enable != 4'b0000) || (memory__address != 32'h0)))
         berr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tohost_q <= '0;
         halt_q   <= 1'b0;
         cvalid_q <= 1'b0;
         cdata_q  <= '0;
         berr_q   <= 1'b0;
      end else begin
         tohost_q <= tohost_d;
         halt_q   <= halt_d;
         cvalid_q <= cvalid_d;
         cdata_q  <= cdata_d;
         berr_q   <= berr_d;
      end
   end

   assign halt          = halt_q;
   assign console_valid = cvalid_q;
   assign console_data  = cdata_q;
   assign bus_error     = berr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   localparam int          MEM_WORDS = 4096;
   localparam int          TICK_DIV  = 4;
   localparam logic [31:0] MMIO      = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  we;
   logic        timer_irq, halt, console_valid, bus_error;
   logic [7:0]  console_data;

   int checks   = 0;
   int failures = 0;

   // Behavioural reference state
   logic [63:0] m_mtime, m_cmp;
   int          m_presc;
   logic        m_irq, m_halt, m_cv, m_berr;
   logic [7:0]  m_cd;
   logic [31:0] m_tohost;
   logic [31:0] ram_m [int];
   int          words [$];

   always #5 clk = ~clk;

   data_mem_responder #(
      .MEM_WORDS (MEM_WORDS),
      .MMIO_BASE (MMIO),
      .TICK_DIV  (TICK_DIV),
      .INIT_FILE ("")
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .memory__address      (addr),
      .memory__write_data   (wdata),
      .memory__write_enable (we),
      .memory__read_data    (rdata),
      .timer_irq            (timer_irq),
      .halt                 (halt),
      .console_valid        (console_valid),
      .console_data         (console_data),
      .bus_error            (bus_error)
   );

   function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] w);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   // 0 = RAM, 1 = MMIO, 2 = miss
   function automatic int region_of(input logic [31:0] a);
      if (a < 32'(MEM_WORDS * 4)) return 0;
      if (a >= MMIO && a <= MMIO + 32'h3F) return 1;
      return 2;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int off;
      off = int'(a - MMIO) & 32'h3C;
      case (region_of(a))
         0: return ram_m.exists(int'(a >> 2)) ? ram_m[int'(a >> 2)] : 32'h0;
         1: case (off)
               'h00: return m_mtime[31:0];
               'h04: return m_mtime[63:32];
               'h08: return m_cmp[31:0];
               'h0C: return m_cmp[63:32];
               'h10: return m_tohost;
               default: return 32'h0;
            endcase
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_mtime = 64'd0; m_cmp = '1; m_presc = 0; m_irq = 0; m_halt = 0;
      m_cv = 0; m_cd = 8'h0; m_berr = 0; m_tohost = 32'h0;
   endtask

   // Apply the architectural effect of one clock edge with the given access.
   task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      bit          tick, mt_wr;
      int          rg, off;
      logic [63:0] t;
      tick  = (m_presc == TICK_DIV - 1);
      rg    = region_of(a);
      off   = int'(a - MMIO) & 32'h3C;
      t     = m_mtime;
      mt_wr = 0;
      m_irq = (m_mtime >= m_cmp);
      m_cv  = 0;
      if (rg == 0 && w != 0) begin
         ram_m[int'(a >> 2)] = lanes(model_read(a), d, w);
      end
      if (rg == 1 && w != 0) begin
         case (off)
            'h00: begin t[31:0]  = lanes(m_mtime[31:0], d, w);  mt_wr = 1; end
            'h04: begin t[63:32] = lanes(m_mtime[63:32], d, w); mt_wr = 1; end
            'h08: m_cmp[31:0]  = lanes(m_cmp[31:0], d, w);
            'h0C: m_cmp[63:32] = lanes(m_cmp[63:32], d, w);
            'h10: begin
               m_tohost = lanes(m_tohost, d, w);
               if (m_tohost != 0) m_halt = 1;
            end
            'h14: if (w[0]) begin m_cv = 1; m_cd = d[7:0]; end
            default: ;
         endcase
      end
      if (!mt_wr && tick) t = t + 64'd1;
      m_mtime = t;
      m_presc = tick ? 0 : m_presc + 1;
      if (rg == 2 && (w != 0 || a != 0)) m_berr = 1;
   endtask

   task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      addr = a; wdata = d; we = w;
      @(posedge clk);
      model_edge(a, d, w);
      #1;
      addr = 32'h0; wdata = 32'h0; we = 4'h0;
   endtask

   task automatic do_reset();
      reset = 1'b0; addr = 32'h0; wdata = 32'h0; we = 4'h0;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 5;
      if (timer_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0b exp=0", timer_irq); end
      if (halt !== 1'b0) begin failures++; $display("FAIL reset_halt got=%0b exp=0", halt); end
      if (console_valid !== 1'b0) begin failures++; $display("FAIL reset_cvalid got=%0b exp=0", console_valid); end
      if (console_data !== 8'h00) begin failures++; $display("FAIL reset_cdata got=%h exp=00", console_data); end
      if (bus_error !== 1'b0) begin failures++; $display("FAIL reset_berr got=%0b exp=0", bus_error); end
      addr = MMIO + 32'h8; #1;
      checks++;
      if (rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp_lo got=%h exp=ffffffff", rdata); end
   endtask

   task automatic test_timer_count();
      do_reset();
      for (int i = 0; i <= 400; i++) begin
         addr = MMIO; #1;
         checks++;
         if (rdata !== m_mtime[31:0]) begin failures++; $display("FAIL mtime_track i=%0d got=%0d exp=%0d", i, rdata, m_mtime[31:0]); end
         if (i == 0 || i == 3 || i == 4 || i == 400) begin
            checks++;
            if (rdata !== 32'(i / 4)) begin failures++; $display("FAIL mtime_count i=%0d got=%0d exp=%0d", i, rdata, i / 4); end
         end
         cycle(MMIO, 32'h0, 4'h0);
      end
   endtask

   task automatic test_ram_lanes();
      logic [31:0] a;
      cycle(32'h100, 32'hDEAD_BEEF, 4'b1111);
      cycle(32'h100, 32'h0000_00AA, 4'b0001);
      addr = 32'h100; #1;
      checks++;
      if (rdata !== 32'hDEAD_BEAA) begin failures++; $display("FAIL ram_lane_100 got=%h exp=deadbeaa", rdata); end
      addr = 32'h102; #1;
      checks++;
      if (rdata !== 32'hDEAD_BEAA) begin failures++; $display("FAIL ram_lane_102 got=%h exp=deadbeaa", rdata); end
      words.push_back(64);
      for (int k = 0; k < 8; k++) begin
         cycle(32'((80 + k) * 4), $urandom, 4'b1111);
         words.push_back(80 + k);
      end
      for (int k = 0; k < 16; k++) begin
         a = 32'((80 + $urandom_range(0, 7)) * 4);
         cycle(a, $urandom, 4'($urandom_range(1, 15)));
      end
      for (int k = 0; k < 8; k++) begin
         a = 32'((80 + k) * 4) | 32'($urandom_range(0, 3));
         addr = a; #1;
         checks++;
         if (rdata !== model_read(a)) begin failures++; $display("FAIL ram_rand a=%h got=%h exp=%h", a, rdata, model_read(a)); end
         cycle(32'h0, 32'h0, 4'h0);
      end
   endtask

   task automatic test_compare_irq();
      bit found;
      do_reset();
      cycle(MMIO + 32'h4, 32'd0, 4'hF);
      cycle(MMIO + 32'h0, 32'd40, 4'hF);
      cycle(MMIO + 32'hC, 32'd0, 4'hF);
      cycle(MMIO + 32'h8, 32'd50, 4'hF);
      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         addr = MMIO; #1;
         if (rdata == 32'd50) begin
            found = 1;
            checks++;
            if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_before got=%0b exp=0", timer_irq); end
            cycle(MMIO, 32'h0, 4'h0);
            checks++;
            if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%0b exp=1", timer_irq); end
         end else begin
            checks++;
            if (timer_irq !== m_irq) begin failures++; $display("FAIL irq_track got=%0b exp=%0b", timer_irq, m_irq); end
            cycle(MMIO, 32'h0, 4'h0);
         end
      end
      if (!found) begin
         checks++; failures++;
         $display("FAIL irq_timeout got=no_mtime_50 exp=mtime_50_within_400_cycles");
      end
      cycle(MMIO + 32'h8, 32'd1000, 4'hF);
      checks++;
      if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_hold got=%0b exp=1", timer_irq); end
      cycle(32'h0, 32'h0, 4'h0);
      checks++;
      if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_drop got=%0b exp=0", timer_irq); end
   endtask

   task automatic test_carry_collision();
      logic [63:0] old;
      cycle(MMIO + 32'h0, 32'hFFFF_FFFF, 4'hF);
      cycle(MMIO + 32'h4, 32'h0, 4'hF);
      repeat (4) cycle(32'h0, 32'h0, 4'h0);
      addr = MMIO + 32'h4; #1;
      checks++;
      if (rdata !== 32'd1) begin failures++; $display("FAIL carry_hi got=%h exp=00000001", rdata); end
      addr = MMIO; #1;
      checks++;
      if (rdata !== 32'd0) begin failures++; $display("FAIL carry_lo got=%h exp=00000000", rdata); end
      for (int i = 0; i < 4 && m_presc != TICK_DIV - 1; i++) cycle(32'h0, 32'h0, 4'h0);
      old = m_mtime;
      cycle(MMIO, 32'hA5A5_A555, 4'b0001);
      addr = MMIO; #1;
      checks++;
      if (rdata !== {old[31:8], 8'h55}) begin failures++; $display("FAIL collide_lo got=%h exp=%h", rdata, {old[31:8], 8'h55}); end
      addr = MMIO + 32'h4; #1;
      checks++;
      if (rdata !== old[63:32]) begin failures++; $display("FAIL collide_hi got=%h exp=%h", rdata, old[63:32]); end
   endtask

   task automatic test_bus_error();
      addr = MMIO + 32'h20; #1;
      checks++;
      if (rdata !== 32'h0) begin failures++; $display("FAIL rsvd_read got=%h exp=0", rdata); end
      cycle(MMIO + 32'h20, 32'h0, 4'h0);
      cycle(MMIO + 32'h24, 32'h1234, 4'hF);
      checks++;
      if (bus_error !== 1'b0) begin failures++; $display("FAIL berr_rsvd got=%0b exp=0", bus_error); end
      cycle(32'h0, 32'hA5A5_A5A5, 4'hF);
      words.push_back(0);
      addr = 32'h8000_0000; #1;
      checks++;
      if (rdata !== 32'h0) begin failures++; $display("FAIL miss_read got=%h exp=0", rdata); end
      cycle(32'h8000_0000, 32'hFFFF_FFFF, 4'hF);
      checks++;
      if (bus_error !== 1'b1) begin failures++; $display("FAIL berr_set got=%0b exp=1", bus_error); end
      addr = 32'h0; #1;
      checks++;
      if (rdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL miss_nowrite got=%h exp=a5a5a5a5", rdata); end
      cycle(32'h0, 32'h0, 4'h0);
      checks++;
      if (bus_error !== 1'b1) begin failures++; $display("FAIL berr_sticky got=%0b exp=1", bus_error); end
   endtask

   task automatic test_random();
      logic [31:0] a, d;
      logic [3:0]  w;
      do_reset();
      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 2))
            0: a = 32'(words[$urandom_range(0, words.size() - 1)] * 4) | 32'($urandom_range(0, 3));
            1: a = MMIO | 32'($urandom_range(0, 63));
            default: a = 32'h0001_0000 | ($urandom & 32'h0FFF_FFFF);
         endcase
         d = $urandom;
         w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
         addr = a; wdata = d; we = w; #1;
         checks++;
         if (rdata !== model_read(a)) begin failures++; $display("FAIL rand_read a=%h got=%h exp=%h", a, rdata, model_read(a)); end
         cycle(a, d, w);
         checks++;
         if ({timer_irq, halt, console_valid, console_data, bus_error} !== {m_irq, m_halt, m_cv, m_cd, m_berr}) begin
            failures++;
            $display("FAIL rand_outs a=%h got=%b exp=%b", a, {timer_irq, halt, console_valid, console_data, bus_error},
                     {m_irq, m_halt, m_cv, m_cd, m_berr});
         end
      end
   endtask

   task automatic test_console_tohost();
      do_reset();
      cycle(32'h200, 32'h1234_5678, 4'hF);
      cycle(MMIO + 32'h14, 32'h48, 4'b0001);
      checks++;
      if ({console_valid, console_data} !== {1'b1, 8'h48}) begin failures++; $display("FAIL console_H got=%b_%h exp=1_48", console_valid, console_data); end
      cycle(MMIO + 32'h14, 32'h69, 4'b0001);
      checks++;
      if ({console_valid, console_data} !== {1'b1, 8'h69}) begin failures++; $display("FAIL console_i got=%b_%h exp=1_69", console_valid, console_data); end
      cycle(MMIO + 32'h14, 32'h77, 4'b0010);
      checks++;
      if ({console_valid, console_data} !== {1'b0, 8'h69}) begin failures++; $display("FAIL console_lane got=%b_%h exp=0_69", console_valid, console_data); end
      checks++;
      if (halt !== 1'b0) begin failures++; $display("FAIL halt_init got=%0b exp=0", halt); end
      cycle(MMIO + 32'h10, 32'h1, 4'hF);
      checks++;
      if (halt !== 1'b1) begin failures++; $display("FAIL halt_set got=%0b exp=1", halt); end
      cycle(MMIO + 32'h10, 32'h0, 4'hF);
      checks++;
      if (halt !== 1'b1) begin failures++; $display("FAIL halt_sticky got=%0b exp=1", halt); end
      reset = 1'b0; #1;
      checks++;
      if (halt !== 1'b0) begin failures++; $display("FAIL halt_async got=%0b exp=0", halt); end
      model_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      addr = 32'h200; #1;
      checks++;
      if (rdata !== 32'h1234_5678) begin failures++; $display("FAIL ram_keep got=%h exp=12345678", rdata); end
   endtask

   initial begin
      reset = 1'b0; addr = 32'h0; wdata = 32'h0; we = 4'h0;
      model_reset();
      test_reset();
      test_timer_count();
      test_ram_lanes();
      test_compare_irq();
      test_carry_collision();
      test_bus_error();
      test_random();
      test_console_tohost();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
